// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
// imem_we is a one-cycle strobe with no ready: the memory must accept a write in any cycle it is asserted.
interface uart_program_loader_if #(
    parameter int ADDR_W = 12
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: header 0xA5, 16-bit word count, 4*N little-endian data bytes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_program_loader #(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 115200,
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  start,
    uart_program_loader_if.master imem,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [4:0]            state_dbg
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV) + 1;
    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CNT_L, S_CNT_H, S_DATA, S_CHK, S_DONE, S_ERR
    } ld_state_t;

    // ---------------- receiver ----------------
    logic             rx_meta, rx_s, rx_prev;
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             byte_valid, frame_err;

    // Synchroniser flops reset to the idle-high level so reset release cannot fake a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == CNT_W'(HALF - 1)) begin
                    rx_cnt_n = '0;
                    if (rx_s) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_bit_n   = '0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_W'(DIV - 1)) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_W'(DIV - 1)) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = !rx_s;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- loader ----------------
    ld_state_t         st, st_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [15:0]       cnt, cnt_n;
    logic [15:0]       cnt_full;
    logic [31:0]       word, word_n;
    logic [1:0]        pos, pos_n;
    logic [7:0]        chk, chk_n;
    logic              last_q, last_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    ld_state_t         fin_state;

    assign cnt_full  = {rx_shift, cnt[7:0]};
    assign fin_state = CHK_EN ? S_CHK : S_DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            word    <= '0;
            pos     <= '0;
            chk     <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            st      <= st_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            word    <= word_n;
            pos     <= pos_n;
            chk     <= chk_n;
            last_q  <= last_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
        end
    end

    always_comb begin
        st_n    = st;
        idx_n   = idx;
        cnt_n   = cnt;
        word_n  = word;
        pos_n   = pos;
        chk_n   = chk;
        last_n  = last_q;
        we_n    = 1'b0;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        case (st)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    st_n  = S_HDR;
                    idx_n = '0;
                    pos_n = '0;
                    chk_n = '0;
                end
            end
            S_HDR: begin
                if (byte_valid && rx_shift == 8'hA5) st_n = S_CNT_L;
            end
            S_CNT_L: begin
                if (byte_valid) begin
                    cnt_n = {8'h00, rx_shift};
                    st_n  = S_CNT_H;
                end
            end
            S_CNT_H: begin
                if (byte_valid) begin
                    cnt_n = cnt_full;
                    if (int'(cnt_full) > MAX_WORDS) st_n = S_ERR;
                    else if (cnt_full == 16'd0)     st_n = fin_state;
                    else                            st_n = S_DATA;
                end
            end
            S_DATA: begin
                // Leave DATA only in the cycle the final word's strobe is on the port.
                if (we_q && last_q) begin
                    st_n = fin_state;
                end else if (byte_valid) begin
                    chk_n = chk ^ rx_shift;
                    if (pos == 2'd3) begin
                        we_n    = 1'b1;
                        addr_n  = {idx, 2'b00};
                        wdata_n = {rx_shift, word[31:8]};
                        idx_n   = idx + 1'b1;
                        last_n  = (16'(idx) == cnt - 16'd1);
                        pos_n   = '0;
                    end else begin
                        word_n = {rx_shift, word[31:8]};
                        pos_n  = pos + 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (byte_valid) st_n = (rx_shift == chk) ? S_DONE : S_ERR;
            end
            default: st_n = S_IDLE;
        endcase
        if (frame_err && busy) begin
            st_n = S_ERR;
            we_n = 1'b0;
        end
    end

    assign busy      = (st == S_HDR) || (st == S_CNT_L) || (st == S_CNT_H) ||
                       (st == S_DATA) || (st == S_CHK);
    assign cpu_hold  = busy || (st == S_ERR);
    assign load_done = (st == S_DONE);
    assign load_err  = (st == S_ERR);
    assign state_dbg = {rx_state, st};

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at a reduced bit period; honours LOADER_CHECKSUM_EN.
module tb_uart_program_loader;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic start;
  logic cpu_hold, busy, load_done, load_err;
  logic [4:0] state_dbg;

  uart_program_loader_if #(.ADDR_W(ADDR_W)) imem_if ();

  uart_program_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .MAX_WORDS(1024)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .start(start),
    .imem(imem_if.master),
    .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
    .load_err(load_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [43:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic bv_prev = 1'b0;

  task automatic check(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the next expected {addr,data} and follow a byte by one cycle.
  always @(negedge clk) begin
    if (rst && imem_if.imem_we) begin
      wr_cnt++;
      check("wr_latency", {43'd0, bv_prev}, 44'd1);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {imem_if.imem_addr, imem_if.imem_wdata}, 44'hFFFFFFFFFFF);
      end else begin
        check("wr_addr_data", {imem_if.imem_addr, imem_if.imem_wdata}, exp_q.pop_front());
      end
    end
    bv_prev = dut.byte_valid;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag, input logic h, input logic b,
                             input logic d, input logic e);
    check(tag, {40'd0, cpu_hold, busy, load_done, load_err}, {40'd0, h, b, d, e});
  endtask

  initial begin
    int wr_base;
    rst = 1'b0;
    uart_rx = 1'b1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_flags", {40'd0, cpu_hold, busy, load_done, load_err}, 44'd0);
    check("reset_wr", {imem_if.imem_we, imem_if.imem_addr, imem_if.imem_wdata[30:0]}, 44'd0);
    check("reset_state", {41'd0, state_dbg[2:0]}, 44'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset arrives mid-DATA: three data bytes received, nothing written yet.
    pulse_start();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send_all();
    check("middata_state", {41'd0, state_dbg[2:0]}, 44'd4);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_flags", {40'd0, cpu_hold, busy, load_done, load_err}, 44'd0);
    check("midreset_state", {41'd0, state_dbg[2:0]}, 44'd0);
    check("midreset_we", {43'd0, imem_if.imem_we}, 44'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Two-word image.
    pulse_start();
    check_flags("t2_busy", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({12'h000, 32'h00000013});
    exp_q.push_back({12'h004, 32'h00100093});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h90);
`endif
    send_all();
    check_flags("t2_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_writes", 44'(wr_cnt), 44'd2);
    check("t2_pending", 44'(exp_q.size()), 44'd0);

    // Stray bytes before the header are dropped.
    pulse_start();
    check("t3_hdr", {41'd0, state_dbg[2:0]}, 44'd1);
    exp_q.push_back({12'h000, 32'h12345678});
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h08);
`endif
    send_all();
    check_flags("t3_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_writes", 44'(wr_cnt), 44'd3);

    // N = 1025 exceeds the limit.
    wr_base = wr_cnt;
    pulse_start();
    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_all();
    check_flags("t4_err", 1'b1, 1'b0, 1'b0, 1'b1);
    check("t4_nowrite", 44'(wr_cnt), 44'(wr_base));

    // Glitch on the line is ignored, then a framing error aborts the load.
    pulse_start();
    check_flags("t5_busy", 1'b1, 1'b1, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("t5_glitch_hdr", {41'd0, state_dbg[2:0]}, 44'd1);
    tx_q = '{8'hA5, 8'h01, 8'h00};
    send_all();
    check("t5_data", {41'd0, state_dbg[2:0]}, 44'd4);
    send_byte(8'h11, 1'b0);
    repeat (4) @(negedge clk);
    check_flags("t5_err", 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_nowrite", 44'(wr_cnt), 44'(wr_base));
    pulse_start();
    check_flags("t5_restart", 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_restart_hdr", {41'd0, state_dbg[2:0]}, 44'd1);
    pulse_start();
    check("t5_start_ignored", {41'd0, state_dbg[2:0]}, 44'd1);

    // One-word image; with checksum a bad byte still leaves the word written.
    exp_q.push_back({12'h000, 32'h04030201});
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h05);
    send_all();
    check_flags("t6_badchk", 1'b1, 1'b0, 1'b0, 1'b1);
    check("t6_badchk_wr", 44'(wr_cnt), 44'(wr_base + 1));
    pulse_start();
    exp_q.push_back({12'h000, 32'h04030201});
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_all();
    check_flags("t6_goodchk", 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_goodchk_wr", 44'(wr_cnt), 44'(wr_base + 2));
`else
    send_all();
    check_flags("t6_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_wr", 44'(wr_cnt), 44'(wr_base + 1));
`endif
    check("final_pending", 44'(exp_q.size()), 44'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
